// File: rtl/sram_req_adapter_if.sv
// sram_req_adapter_if: request/response stream and tc_sram pin bundle for sram_req_adapter.
interface sram_req_adapter_if #(
  parameter int unsigned DataWidth = 128,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned BeWidth   = 16
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [AddrWidth-1:0] req_addr_i;
  logic [DataWidth-1:0] req_wdata_i;
  logic [BeWidth-1:0]   req_be_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DataWidth-1:0] rsp_rdata_o;
  logic                 sram_req_o;
  logic                 sram_we_o;
  logic [AddrWidth-1:0] sram_addr_o;
  logic [DataWidth-1:0] sram_wdata_o;
  logic [BeWidth-1:0]   sram_be_o;
  logic [DataWidth-1:0] sram_rdata_i;
  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i, sram_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );
  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i, sram_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );
endinterface

// File: rtl/sram_req_adapter.sv
// sram_req_adapter: valid/ready front end for a single-port tc_sram with credit-protected in-order read responses.
// Define SRAM_REQ_ADAPTER_WRITE_RSP_EN to make writes return a zero-data response as well.
module sram_req_adapter #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RespDepth = 4,
  parameter int unsigned AddrWidth = NumWords > 1 ? $clog2(NumWords) : 1,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input logic               clk_i,
  input logic               rst_ni,
  sram_req_adapter_if.slave bus
);
  localparam int unsigned CW = $clog2(RespDepth + 1);
  localparam int unsigned PW = RespDepth > 1 ? $clog2(RespDepth) : 1;
  logic [CW-1:0]        credits_q, credits_d, cnt_q, cnt_d;
  logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Latency-1:0]   pipe_q, pipe_d;
  logic [DataWidth-1:0] buf_q [RespDepth];
  logic                 hs, issue, push, pop, push_zero;
  assign bus.req_ready_o  = credits_q < CW'(RespDepth);
  assign hs               = bus.req_valid_i & bus.req_ready_o;
  assign bus.sram_req_o   = hs;
  assign bus.sram_we_o    = bus.req_we_i;
  assign bus.sram_addr_o  = bus.req_addr_i;
  assign bus.sram_wdata_o = bus.req_wdata_i;
  assign bus.sram_be_o    = bus.req_be_i;
`ifdef SRAM_REQ_ADAPTER_WRITE_RSP_EN
  // Parallel shift register marks which in-flight slots are writes; those push zero data.
  logic [Latency-1:0] wr_q;
  assign issue     = hs;
  assign push_zero = wr_q[Latency-1];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) wr_q <= '0;
    else wr_q <= Latency'({wr_q, hs & bus.req_we_i});
`else
  assign issue     = hs & ~bus.req_we_i;
  assign push_zero = 1'b0;
`endif
  assign push            = pipe_q[Latency-1];
  assign pop             = bus.rsp_valid_o & bus.rsp_ready_i;
  assign bus.rsp_valid_o = cnt_q != '0;
  assign bus.rsp_rdata_o = buf_q[rptr_q];
  always_comb begin
    pipe_d    = Latency'({pipe_q, issue});
    credits_d = credits_q + CW'(issue) - CW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    wptr_d    = push ? (wptr_q == PW'(RespDepth - 1) ? '0 : wptr_q + PW'(1)) : wptr_q;
    rptr_d    = pop ? (rptr_q == PW'(RespDepth - 1) ? '0 : rptr_q + PW'(1)) : rptr_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q    <= '0;
      credits_q <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      pipe_q    <= pipe_d;
      credits_q <= credits_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end
  // Storage needs no reset: entries are only visible once counted in cnt_q.
  always_ff @(posedge clk_i)
    if (push) buf_q[wptr_q] <= push_zero ? '0 : bus.sram_rdata_i;
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && cnt_q == CW'(RespDepth) && !pop))
    else $error("response buffer overflow");
endmodule
